// File: rtl/spi_pkg.sv
// Shared definitions for the SPI transaction sequencer: bit/edge counts,
// state encoding and the byte-count decode helper.
package spi_pkg;

    localparam int SPI_BITS  = 8;
    localparam int SCK_EDGES = 2 * SPI_BITS;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_SETUP  = 3'd2;
    localparam logic [2:0] ST_SHIFT  = 3'd3;
    localparam logic [2:0] ST_SETTLE = 3'd4;
    localparam logic [2:0] ST_PUSH   = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_LOAD   = ST_LOAD,
        S_SETUP  = ST_SETUP,
        S_SHIFT  = ST_SHIFT,
        S_SETTLE = ST_SETTLE,
        S_PUSH   = ST_PUSH
    } xfer_state_t;

    // A length field of zero encodes a full 256-byte transaction.
    function automatic logic [8:0] byte_count(input logic [7:0] len);
        return (len == 8'd0) ? 9'd256 : {1'b0, len};
    endfunction

endpackage

// File: rtl/spi_edge_mon.sv
// Watches the engine serial clock while a byte is shifting: counts sck
// edges and measures the idle time between them.
module spi_edge_mon
    import spi_pkg::*;
#(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic sck,
    output logic edge16,
    output logic timeout
);

    localparam int EW = $clog2(SCK_EDGES + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    logic          sck_reg;
    logic [EW-1:0] edge_cnt_reg;
    logic [TW-1:0] to_cnt_reg;
    logic          sck_edge;

    // sck comes from the same clock, so a single sample flop is enough.
    assign sck_edge = sck ^ sck_reg;

    // Sample sck every cycle so the reference level is valid on SHIFT entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_reg <= 1'b0;
        end else begin
            sck_reg <= sck;
        end
    end

    // Edge counter and inter-edge timer; both idle at zero outside SHIFT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_cnt_reg <= '0;
            to_cnt_reg   <= '0;
        end else if (!en) begin
            edge_cnt_reg <= '0;
            to_cnt_reg   <= '0;
        end else if (sck_edge) begin
            edge_cnt_reg <= edge_cnt_reg + EW'(1);
            to_cnt_reg   <= '0;
        end else begin
            to_cnt_reg   <= to_cnt_reg + TW'(1);
        end
    end

    assign edge16  = en && sck_edge && (edge_cnt_reg == EW'(SCK_EDGES - 1));
    assign timeout = en && !sck_edge && (to_cnt_reg == TW'(TIMEOUT - 1));

endmodule

// File: rtl/spi_xfer_ctrl.sv
// Multi-byte transaction sequencer in front of the byte-wide SPI master
// engine: one engine byte per host TX byte, RX byte returned per byte.
module spi_xfer_ctrl
    import spi_pkg::*;
#(
    parameter int GAP_CYC = 4,
    parameter int SETTLE  = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] len,
    output logic       busy,
    output logic       done,
    output logic       err,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       eng_ms,
    output logic [7:0] eng_tdata,
    input  logic       eng_sck,
    input  logic [7:0] eng_rdata
);

    localparam int GW = $clog2(GAP_CYC + 1);
    localparam int SW = $clog2(SETTLE + 1);

    xfer_state_t         state_reg, state_next;
    logic [8:0]          remaining_reg, remaining_next;
    logic [SPI_BITS-1:0] tdata_reg, tdata_next;
    logic [GW-1:0]       gap_reg, gap_next;
    logic [SW-1:0]       settle_reg, settle_next;
    logic [SPI_BITS-1:0] rx_data_reg, rx_data_next;
    logic                rx_valid_reg, rx_valid_next;
    logic                done_reg, done_next;
    logic                err_reg, err_next;
    logic                ms_reg, ms_next;
    logic                edge16;
    logic                timeout;

    spi_edge_mon #(
        .TIMEOUT (TIMEOUT)
    ) u_edge_mon (
        .clk     (clk),
        .rst     (rst),
        .en      (state_reg == S_SHIFT),
        .sck     (eng_sck),
        .edge16  (edge16),
        .timeout (timeout)
    );

    // State and datapath registers; eng_ms resets high so the engine stops at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            remaining_reg <= '0;
            tdata_reg     <= '0;
            gap_reg       <= '0;
            settle_reg    <= '0;
            rx_data_reg   <= '0;
            rx_valid_reg  <= 1'b0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
            ms_reg        <= 1'b1;
        end else begin
            state_reg     <= state_next;
            remaining_reg <= remaining_next;
            tdata_reg     <= tdata_next;
            gap_reg       <= gap_next;
            settle_reg    <= settle_next;
            rx_data_reg   <= rx_data_next;
            rx_valid_reg  <= rx_valid_next;
            done_reg      <= done_next;
            err_reg       <= err_next;
            ms_reg        <= ms_next;
        end
    end

    // Next-state and register-update logic for the per-byte sequence.
    always_comb begin
        state_next     = state_reg;
        remaining_next = remaining_reg;
        tdata_next     = tdata_reg;
        gap_next       = gap_reg;
        settle_next    = settle_reg;
        rx_data_next   = rx_data_reg;
        rx_valid_next  = rx_valid_reg;
        done_next      = 1'b0;
        err_next       = 1'b0;
        ms_next        = ms_reg;

        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    remaining_next = byte_count(len);
                    state_next     = S_LOAD;
                end
            end
            S_LOAD: begin
                if (tx_valid) begin
                    tdata_next = tx_data;
                    gap_next   = '0;
                    state_next = S_SETUP;
                end
            end
            S_SETUP: begin
                // tdata is already stable; ms drops only after the full gap.
                if (gap_reg == GW'(GAP_CYC - 1)) begin
                    ms_next    = 1'b0;
                    state_next = S_SHIFT;
                end else begin
                    gap_next = gap_reg + GW'(1);
                end
            end
            S_SHIFT: begin
                if (timeout) begin
                    // Stalled engine: abort, dropping the pending byte and the rest.
                    ms_next        = 1'b1;
                    err_next       = 1'b1;
                    remaining_next = '0;
                    state_next     = S_IDLE;
                end else if (edge16) begin
                    ms_next     = 1'b1;
                    settle_next = '0;
                    state_next  = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (settle_reg == SW'(SETTLE - 1)) begin
                    rx_data_next  = eng_rdata;
                    rx_valid_next = 1'b1;
                    state_next    = S_PUSH;
                end else begin
                    settle_next = settle_reg + SW'(1);
                end
            end
            S_PUSH: begin
                // Host may stall here indefinitely; no timeout applies.
                if (rx_ready) begin
                    rx_valid_next  = 1'b0;
                    remaining_next = remaining_reg - 9'd1;
                    if (remaining_reg == 9'd1) begin
                        done_next  = 1'b1;
                        state_next = S_IDLE;
                    end else begin
                        state_next = S_LOAD;
                    end
                end
            end
            default: begin
                ms_next    = 1'b1;
                state_next = S_IDLE;
            end
        endcase
    end

    assign busy      = (state_reg != S_IDLE);
    assign tx_ready  = (state_reg == S_LOAD);
    assign done      = done_reg;
    assign err       = err_reg;
    assign rx_data   = rx_data_reg;
    assign rx_valid  = rx_valid_reg;
    assign eng_ms    = ms_reg;
    assign eng_tdata = tdata_reg;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Self-checking bench for spi_xfer_ctrl: loopback engine model, host TX/RX
// agents, a transaction-level reference model checked every cycle, and
// directed scenarios with hand-computed expectations.
module tb_spi_xfer_ctrl;

    localparam int GAP  = 4;
    localparam int SET  = 2;
    localparam int TO   = 16;
    localparam int HALF = 2;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] len;
    logic       busy, done, err;
    logic [7:0] tx_data;
    logic       tx_valid, tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid, rx_ready;
    logic       eng_ms;
    logic [7:0] eng_tdata;
    logic       eng_sck;
    logic [7:0] eng_rdata;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int err_cnt = 0;

    logic [7:0] tx_q[$];
    logic [7:0] rx_got[$];
    logic [7:0] rx_exp[$];
    bit rx_stall = 0;
    bit freeze_en = 0;
    int freeze_at = 0;

    spi_xfer_ctrl #(
        .GAP_CYC (GAP),
        .SETTLE  (SET),
        .TIMEOUT (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .eng_ms    (eng_ms),
        .eng_tdata (eng_tdata),
        .eng_sck   (eng_sck),
        .eng_rdata (eng_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Host TX agent: presents the head of tx_q, pops on handshake.
    initial begin
        bit hs;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        forever begin
            @(negedge clk);
            hs = tx_valid && tx_ready;
            @(posedge clk);
            #1;
            if (hs && tx_q.size() > 0) void'(tx_q.pop_front());
            tx_valid = (tx_q.size() > 0);
            tx_data  = (tx_q.size() > 0) ? tx_q[0] : 8'h00;
        end
    end

    // Host RX agent: accepts unless stalled, records every accepted byte.
    initial begin
        rx_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (rx_valid && rx_ready) begin
                rx_got.push_back(rx_data);
                $display("rx byte %02h", rx_data);
            end
            @(posedge clk);
            #1;
            rx_ready = !rx_stall;
        end
    end

    // Engine model: mode-0 style byte, HALF clk per sck phase, MSB first,
    // serial out looped back to serial in. Optionally freezes sck mid-byte.
    initial begin
        logic [7:0] sh;
        logic [7:0] rxb;
        int cyc;
        int nedges;
        bit aborted;
        eng_sck   = 1'b0;
        eng_rdata = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (!rst && !eng_ms) begin
                sh = eng_tdata;
                rxb = 8'h00;
                cyc = 0;
                nedges = 0;
                aborted = 0;
                while (!aborted && nedges < 16) begin
                    @(posedge clk);
                    #1;
                    if (rst || eng_ms) begin
                        aborted = 1;
                    end else begin
                        cyc++;
                        if (cyc >= HALF && !(freeze_en && nedges == freeze_at)) begin
                            cyc = 0;
                            eng_sck = ~eng_sck;
                            nedges++;
                            if (eng_sck) begin
                                rxb = {rxb[6:0], sh[7]};
                                eng_rdata = rxb;
                            end else begin
                                sh = {sh[6:0], 1'b0};
                            end
                        end
                    end
                end
                eng_sck = 1'b0;
                while (!eng_ms && !rst) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
    end

    // Reference model and per-cycle comparison, sampled on the falling edge.
    initial begin
        bit m_busy;
        int m_rem;
        bit pend_done;
        bit pend_err;
        int m_to;
        int ms_run;
        bit rx_taken;
        logic prev_sck, prev_ms, prev_rxv;
        logic [7:0] prev_tdata, prev_rxd, exp_b;
        m_busy = 0; m_rem = 0; pend_done = 0; pend_err = 0; m_to = 0;
        ms_run = 0; rx_taken = 0;
        prev_sck = 0; prev_ms = 1; prev_rxv = 0; prev_tdata = 0; prev_rxd = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                chk("rst_err", err, 0);
                chk("rst_tx_ready", tx_ready, 0);
                chk("rst_rx_valid", rx_valid, 0);
                chk("rst_rx_data", rx_data, 0);
                chk("rst_eng_ms", eng_ms, 1);
                chk("rst_eng_tdata", eng_tdata, 0);
                m_busy = 0; m_rem = 0; pend_done = 0; pend_err = 0; m_to = 0;
                rx_exp.delete();
                ms_run = 0; rx_taken = 0;
                prev_sck = eng_sck; prev_ms = 1; prev_tdata = eng_tdata;
                prev_rxv = 0; prev_rxd = rx_data;
            end else begin
                chk("done", done, pend_done);
                chk("err", err, pend_err);
                chk("busy", busy, m_busy);
                if (done) done_cnt++;
                if (err) err_cnt++;
                chk("tx_ready_with_done_err", tx_ready && (done || err), 0);
                chk("done_and_err", done && err, 0);
                if (tx_ready || rx_valid || !busy) chk("ms_high", eng_ms, 1);
                if (!m_busy) begin
                    chk("idle_tx_ready", tx_ready, 0);
                    chk("idle_rx_valid", rx_valid, 0);
                end
                if (eng_tdata != prev_tdata) chk("tdata_change_ms_low", prev_ms && eng_ms, 1);
                if (prev_rxv && !rx_taken) begin
                    chk("rx_valid_hold", rx_valid, 1);
                    chk("rx_data_hold", rx_data, prev_rxd);
                end
                if (prev_ms && !eng_ms) chk("ms_gap", ms_run >= GAP + 1, 1);
                ms_run = eng_ms ? ms_run + 1 : 0;

                // Events taking effect at the coming rising edge.
                pend_done = 0;
                pend_err  = 0;
                rx_taken  = 0;
                if (start && !m_busy) begin
                    m_busy = 1;
                    m_rem  = (len == 8'd0) ? 256 : int'(len);
                end
                if (tx_valid && tx_ready) begin
                    chk("tx_without_rx", rx_exp.size(), 0);
                    rx_exp.push_back(tx_data);
                end
                if (rx_valid && rx_ready) begin
                    rx_taken = 1;
                    if (rx_exp.size() == 0) begin
                        chk("rx_unexpected", 1, 0);
                    end else begin
                        exp_b = rx_exp.pop_front();
                        chk("rx_byte", rx_data, exp_b);
                    end
                    m_rem--;
                    if (m_rem == 0) begin
                        pend_done = 1;
                        m_busy = 0;
                    end
                end
                if (eng_ms || eng_sck != prev_sck) begin
                    m_to = 0;
                end else begin
                    m_to++;
                    if (m_to == TO) begin
                        pend_err = 1;
                        m_busy = 0;
                        m_rem = 0;
                        rx_exp.delete();
                        m_to = 0;
                    end
                end
                prev_sck = eng_sck; prev_ms = eng_ms; prev_tdata = eng_tdata;
                prev_rxv = rx_valid; prev_rxd = rx_data;
            end
        end
    end

    task automatic pulse_start(input logic [7:0] l);
        start = 1'b1;
        len   = l;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_end(input int maxc, output int ncyc);
        int base;
        base = done_cnt + err_cnt;
        ncyc = -1;
        for (int n = 1; n <= maxc; n++) begin
            @(negedge clk);
            #1;
            if (done_cnt + err_cnt != base) begin
                ncyc = n;
                break;
            end
        end
        if (ncyc < 0) chk("end_wait_expired", 0, 1);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Watchdog: the run must never hang.
    initial begin
        #400000;
        $display("FAIL watchdog expired at %0t", $time);
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

    initial begin
        int ncyc;
        int d0, e0;
        bit seen;
        rst = 1'b1;
        start = 1'b0;
        len = 8'd0;
        cycles(3);
        rst = 1'b0;
        cycles(2);

        // len=1, 0xA5 loopback; latency from start hand-traced as 42 cycles after start drop.
        tx_q.push_back(8'hA5);
        rx_got.delete();
        d0 = done_cnt;
        pulse_start(8'd1);
        wait_end(300, ncyc);
        chk("len1_latency", ncyc, 42);
        chk("len1_rx_count", rx_got.size(), 1);
        if (rx_got.size() > 0) chk("len1_rx_byte", rx_got[0], 8'hA5);
        chk("len1_done_count", done_cnt - d0, 1);
        cycles(1);
        chk("len1_busy_after", busy, 0);
        $display("xfer len=1 done");

        // len=3 in order.
        tx_q.push_back(8'h01); tx_q.push_back(8'h80); tx_q.push_back(8'hFF);
        rx_got.delete();
        d0 = done_cnt;
        pulse_start(8'd3);
        wait_end(600, ncyc);
        chk("len3_rx_count", rx_got.size(), 3);
        if (rx_got.size() == 3) begin
            chk("len3_rx0", rx_got[0], 8'h01);
            chk("len3_rx1", rx_got[1], 8'h80);
            chk("len3_rx2", rx_got[2], 8'hFF);
        end
        chk("len3_done_count", done_cnt - d0, 1);
        $display("xfer len=3 done");
        cycles(3);

        // Host stalls RX for 50 cycles.
        rx_stall = 1;
        tx_q.push_back(8'h3C);
        rx_got.delete();
        pulse_start(8'd1);
        seen = 0;
        for (int n = 0; n < 300 && !seen; n++) begin
            @(negedge clk);
            #1;
            seen = rx_valid;
        end
        chk("stall_rx_valid_seen", seen, 1);
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            #1;
            chk("stall_rx_valid", rx_valid, 1);
            chk("stall_rx_data", rx_data, 8'h3C);
            chk("stall_tx_ready", tx_ready, 0);
            chk("stall_eng_ms", eng_ms, 1);
        end
        rx_stall = 0;
        wait_end(50, ncyc);
        chk("stall_rx_count", rx_got.size(), 1);
        if (rx_got.size() > 0) chk("stall_rx_byte", rx_got[0], 8'h3C);
        $display("xfer stall done");
        cycles(3);

        // Engine freezes after 5 edges: err 16 cycles after the last edge.
        freeze_en = 1;
        freeze_at = 5;
        tx_q.push_back(8'h5A);
        rx_got.delete();
        d0 = done_cnt;
        e0 = err_cnt;
        pulse_start(8'd1);
        wait_end(300, ncyc);
        chk("timeout_latency", ncyc, 33);
        chk("timeout_err_count", err_cnt - e0, 1);
        chk("timeout_no_done", done_cnt - d0, 0);
        chk("timeout_eng_ms", eng_ms, 1);
        chk("timeout_busy", busy, 0);
        chk("timeout_no_rx", rx_got.size(), 0);
        freeze_en = 0;
        cycles(5);
        chk("timeout_rx_valid_after", rx_valid, 0);
        $display("xfer timeout done");

        // Second start while busy is ignored.
        tx_q.push_back(8'h11); tx_q.push_back(8'h22);
        rx_got.delete();
        d0 = done_cnt;
        pulse_start(8'd2);
        cycles(10);
        pulse_start(8'd5);
        wait_end(600, ncyc);
        cycles(60);
        chk("busy_start_done_count", done_cnt - d0, 1);
        chk("busy_start_rx_count", rx_got.size(), 2);
        if (rx_got.size() == 2) begin
            chk("busy_start_rx0", rx_got[0], 8'h11);
            chk("busy_start_rx1", rx_got[1], 8'h22);
        end
        chk("busy_start_idle", busy, 0);
        $display("xfer start-while-busy done");

        // Reset during SHIFT of byte 2 of 4.
        tx_q.push_back(8'h41); tx_q.push_back(8'h42); tx_q.push_back(8'h43); tx_q.push_back(8'h44);
        rx_got.delete();
        d0 = done_cnt;
        e0 = err_cnt;
        pulse_start(8'd4);
        seen = 0;
        for (int n = 0; n < 300 && !seen; n++) begin
            @(negedge clk);
            #1;
            seen = (rx_got.size() == 1) && !eng_ms;
        end
        chk("rst_test_in_shift", seen, 1);
        cycles(6);
        rst = 1'b1;
        #1;
        chk("arst_eng_ms", eng_ms, 1);
        chk("arst_busy", busy, 0);
        chk("arst_tx_ready", tx_ready, 0);
        chk("arst_rx_valid", rx_valid, 0);
        chk("arst_rx_data", rx_data, 0);
        chk("arst_eng_tdata", eng_tdata, 0);
        chk("arst_done", done, 0);
        chk("arst_err", err, 0);
        tx_q.delete();
        cycles(3);
        rst = 1'b0;
        cycles(5);
        chk("rst_no_done", done_cnt - d0, 0);
        chk("rst_no_err", err_cnt - e0, 0);
        tx_q.push_back(8'h77);
        rx_got.delete();
        pulse_start(8'd1);
        wait_end(300, ncyc);
        chk("post_rst_rx_count", rx_got.size(), 1);
        if (rx_got.size() > 0) chk("post_rst_rx_byte", rx_got[0], 8'h77);
        chk("post_rst_done_count", done_cnt - d0, 1);
        $display("xfer after reset done");
        cycles(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
